npc_pc_unit: RTL and testbench

- Fetch-side program-counter stage that consumes the ID-stage comparator result codes.
- Holds the architectural fetch PC and resolves branch and jump decisions from the comparator codes. It redirects fetch using MIPS delayed-branch semantics.
- Fetch back-pressure is handled by capturing a resolved redirect until instruction memory can accept it.

---
 rtl/npc_pc_unit_pkg.sv | 31 +++
 rtl/npc_pc_unit_if.sv | 34 +++
 rtl/npc_pc_unit_branch_target_calc.sv | 53 +++++
 rtl/npc_pc_unit.sv | 92 +++++++++
 tb/tb_npc_pc_unit.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pc_unit_pkg.sv
// npc_pc_unit_pkg: shared constants and types for the fetch-side PC unit.
// Holds the branch-class codes from ID, the comparator result codes,
// the default reset PC and the RUN/PEND state encoding.
package npc_pc_unit_pkg;

  localparam int          BR_W     = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [BR_W-1:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BGTZ = 4'd3,
    BR_BLEZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9
  } br_type_e;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/npc_pc_unit_if.sv
// npc_pc_unit_if: bundles the ID-stage branch inputs, the fetch handshake
// and the PC-unit outputs.
//   master : ID/fetch side, drives stall, imem_ready and the branch fields
//   slave  : the PC unit, drives pc, link_addr, redirect, pending, misalign
interface npc_pc_unit_if;
  import npc_pc_unit_pkg::*;

  logic            stall;
  logic            imem_ready;
  logic [BR_W-1:0] br_type;
  logic [1:0]      cmp_reg;
  logic [1:0]      cmp_zero;
  logic [31:0]     id_pc;
  logic [15:0]     imm16;
  logic [25:0]     instr_index;
  logic [31:0]     rs_data;
  logic [31:0]     pc;
  logic [31:0]     link_addr;
  logic            redirect;
  logic            pending;
  logic            misalign;

  modport master (
    output stall, imem_ready, br_type, cmp_reg, cmp_zero, id_pc, imm16,
           instr_index, rs_data,
    input  pc, link_addr, redirect, pending, misalign
  );

  modport slave (
    input  stall, imem_ready, br_type, cmp_reg, cmp_zero, id_pc, imm16,
           instr_index, rs_data,
    output pc, link_addr, redirect, pending, misalign
  );
endinterface

// File: rtl/npc_pc_unit_branch_target_calc.sv
// npc_pc_unit_branch_target_calc: purely combinational branch resolution.
// Inputs : br_type, cmp_reg, cmp_zero, id_pc, imm16, instr_index, rs_data
// Outputs: taken  - ID branch/jump condition holds
//          target - redirect address (branch, J/JAL region, or JR register)
module npc_pc_unit_branch_target_calc
  import npc_pc_unit_pkg::*;
(
  input  logic [BR_W-1:0] br_type,
  input  logic [1:0]      cmp_reg,
  input  logic [1:0]      cmp_zero,
  input  logic [31:0]     id_pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     instr_index,
  input  logic [31:0]     rs_data,
  output logic            taken,
  output logic [31:0]     target
);

  logic [31:0] id_pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jump_target;

  assign id_pc_plus4 = id_pc + 32'd4;
  // Word offset, sign-extended; sums wrap at 2^32 by design.
  assign br_offset   = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target   = id_pc_plus4 + br_offset;
  // J/JAL stay within the 256 MB region of the delay-slot instruction.
  assign jump_target = {id_pc_plus4[31:28], instr_index, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (br_type)
      BR_BEQ:  taken = (cmp_reg == CMP_EQ);
      BR_BNE:  taken = (cmp_reg != CMP_EQ);
      BR_BGTZ: taken = (cmp_zero == CMP_GT);
      BR_BLEZ: taken = (cmp_zero != CMP_GT);
      BR_BLTZ: taken = (cmp_zero == CMP_LT);
      BR_BGEZ: taken = (cmp_zero != CMP_LT);
      BR_J, BR_JAL: begin
        taken  = 1'b1;
        target = jump_target;
      end
      BR_JR: begin
        taken  = 1'b1;
        target = rs_data;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_pc_unit.sv
// npc_pc_unit: fetch PC register with delayed-branch redirect.
// Ports: clk, reset (synchronous, active-high), bus (npc_pc_unit_if.slave).
// The delay-slot instruction is already in fetch, so a redirect simply
// replaces the sequential pc+4 step; nothing is flushed. When fetch is
// back-pressured, a resolved target is parked in pend_target (state PEND)
// and loaded on the first cycle with imem_ready && !stall.
module npc_pc_unit #(
  parameter logic [31:0] RESET_PC = npc_pc_unit_pkg::RESET_PC
) (
  input  logic           clk,
  input  logic           reset,
  npc_pc_unit_if.slave   bus
);
  import npc_pc_unit_pkg::*;

  state_e      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_target_reg, pend_target_next;
  logic        misalign_reg, misalign_next;
  logic        target_load;
  logic        taken;
  logic [31:0] target;
  logic        redirect;

  npc_pc_unit_branch_target_calc u_calc (
    .br_type     (bus.br_type),
    .cmp_reg     (bus.cmp_reg),
    .cmp_zero    (bus.cmp_zero),
    .id_pc       (bus.id_pc),
    .imm16       (bus.imm16),
    .instr_index (bus.instr_index),
    .rs_data     (bus.rs_data),
    .taken       (taken),
    .target      (target)
  );

  // A branch seen while PEND is ignored; upstream never resolves one then.
  assign redirect = taken && (state_reg == ST_RUN) && !bus.stall;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_target_next = pend_target_reg;
    target_load      = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (bus.stall) begin
          pc_next = pc_reg;
        end else if (redirect && bus.imem_ready) begin
          pc_next     = target;
          target_load = 1'b1;
        end else if (redirect) begin
          pend_target_next = target;
          state_next       = ST_PEND;
        end else if (bus.imem_ready) begin
          pc_next = pc_reg + 32'd4;
        end
      end
      ST_PEND: begin
        if (bus.imem_ready && !bus.stall) begin
          pc_next     = pend_target_reg;
          target_load = 1'b1;
          state_next  = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
    // Only redirect targets flag misalignment; sequential steps cannot.
    misalign_next = target_load && (pc_next[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      pc_reg          <= RESET_PC;
      pend_target_reg <= 32'd0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_target_reg <= pend_target_next;
      misalign_reg    <= misalign_next;
    end
  end

  assign bus.pc        = pc_reg;
  assign bus.link_addr = bus.id_pc + 32'd8;
  assign bus.redirect  = redirect;
  assign bus.pending   = (state_reg == ST_PEND);
  assign bus.misalign  = misalign_reg;

endmodule

// File: tb/tb_npc_pc_unit.sv
// tb_npc_pc_unit: directed scenarios plus randomized traffic checked against
// a behavioural model of the PC unit kept in the bench.
module tb_npc_pc_unit;

  logic clk;
  logic reset;
  npc_pc_unit_if bus_if ();

  npc_pc_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;
  bit          m_mis;

  function automatic bit model_taken(int bt, int cr, int cz);
    case (bt)
      1: return cr == 0;
      2: return cr != 0;
      3: return cz == 1;
      4: return cz != 1;
      5: return cz == 2;
      6: return cz != 2;
      7, 8, 9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(int bt, logic [31:0] id_pc,
      logic [15:0] imm, logic [25:0] idx, logic [31:0] rs);
    int off;
    if (bt == 9) return rs;
    if (bt == 7 || bt == 8)
      return ((id_pc + 32'd4) & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    off = int'($signed(imm)) * 4;
    return id_pc + 32'd4 + 32'(off);
  endfunction

  function automatic bit model_redirect();
    return model_taken(int'(bus_if.br_type), int'(bus_if.cmp_reg),
                       int'(bus_if.cmp_zero)) && !m_pend && !bus_if.stall;
  endfunction

  // Advance one clock and update the model from the inputs in force.
  task automatic tick();
    bit          tk;
    bit          load;
    logic [31:0] tg;
    tk = model_taken(int'(bus_if.br_type), int'(bus_if.cmp_reg), int'(bus_if.cmp_zero));
    tg = model_target(int'(bus_if.br_type), bus_if.id_pc, bus_if.imm16,
                      bus_if.instr_index, bus_if.rs_data);
    load = 1'b0;
    if (reset) begin
      m_pc = 32'h0000_3000; m_pend = 1'b0; m_mis = 1'b0; m_tgt = 32'd0;
    end else begin
      if (m_pend) begin
        if (bus_if.imem_ready && !bus_if.stall) begin
          m_pc = m_tgt; m_pend = 1'b0; load = 1'b1;
        end
      end else if (!bus_if.stall) begin
        if (tk && bus_if.imem_ready) begin
          m_pc = tg; load = 1'b1;
        end else if (tk) begin
          m_pend = 1'b1; m_tgt = tg;
        end else if (bus_if.imem_ready) begin
          m_pc = m_pc + 32'd4;
        end
      end
      m_mis = load && (m_pc[1:0] != 2'b00);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.stall       = 1'b0;
    bus_if.imem_ready  = 1'b1;
    bus_if.br_type     = 4'd0;
    bus_if.cmp_reg     = 2'b00;
    bus_if.cmp_zero    = 2'b00;
    bus_if.id_pc       = 32'd0;
    bus_if.imm16       = 16'd0;
    bus_if.instr_index = 26'd0;
    bus_if.rs_data     = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_if.pc !== 32'h0000_3000) begin
      $display("FAIL reset_pc: got %h expected %h", bus_if.pc, 32'h0000_3000); errors++;
    end
    checks++;
    if (bus_if.pending !== 1'b0 || bus_if.misalign !== 1'b0) begin
      $display("FAIL reset_flags: got pending=%b misalign=%b expected 0 0",
               bus_if.pending, bus_if.misalign); errors++;
    end
    $display("reset: pc=%h pending=%b", bus_if.pc, bus_if.pending);
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [3] = '{32'h3004, 32'h3008, 32'h300C};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_if.pc !== exp_seq[i] || bus_if.pending !== 1'b0) begin
        $display("FAIL seq_pc[%0d]: got pc=%h pending=%b expected pc=%h pending=0",
                 i, bus_if.pc, bus_if.pending, exp_seq[i]); errors++;
      end
      $display("seq: pc=%h", bus_if.pc);
    end
  endtask

  task automatic test_beq();
    do_reset();
    tick();  // pc 0x3004
    bus_if.br_type = 4'd1; bus_if.id_pc = 32'h3004; bus_if.imm16 = 16'h0003;
    bus_if.cmp_reg = 2'b00;
    #1;
    checks++;
    if (bus_if.redirect !== 1'b1) begin
      $display("FAIL beq_redirect: got %b expected 1", bus_if.redirect); errors++;
    end
    tick();
    checks++;
    if (bus_if.pc !== 32'h3014) begin
      $display("FAIL beq_taken_pc: got %h expected %h", bus_if.pc, 32'h3014); errors++;
    end
    $display("beq taken: pc=%h", bus_if.pc);
    do_reset();
    tick(); tick();  // pc 0x3008
    bus_if.br_type = 4'd1; bus_if.id_pc = 32'h3004; bus_if.imm16 = 16'h0003;
    bus_if.cmp_reg = 2'b01;
    #1;
    checks++;
    if (bus_if.redirect !== 1'b0) begin
      $display("FAIL beq_nt_redirect: got %b expected 0", bus_if.redirect); errors++;
    end
    tick();
    checks++;
    if (bus_if.pc !== 32'h300C) begin
      $display("FAIL beq_not_taken_pc: got %h expected %h", bus_if.pc, 32'h300C); errors++;
    end
    $display("beq not taken: pc=%h", bus_if.pc);
  endtask

  task automatic test_bltz_bgez();
    do_reset();
    bus_if.br_type = 4'd5; bus_if.id_pc = 32'h3010; bus_if.imm16 = 16'hFFFE;
    bus_if.cmp_zero = 2'b10;
    tick();
    checks++;
    if (bus_if.pc !== 32'h300C) begin
      $display("FAIL bltz_pc: got %h expected %h", bus_if.pc, 32'h300C); errors++;
    end
    $display("bltz: pc=%h", bus_if.pc);
    do_reset();
    bus_if.br_type = 4'd6; bus_if.id_pc = 32'h3010; bus_if.imm16 = 16'hFFFE;
    bus_if.cmp_zero = 2'b10;
    tick();
    checks++;
    if (bus_if.pc !== 32'h3004) begin
      $display("FAIL bgez_pc: got %h expected %h", bus_if.pc, 32'h3004); errors++;
    end
    $display("bgez: pc=%h", bus_if.pc);
  endtask

  task automatic test_jr_backpressure();
    do_reset();
    bus_if.br_type = 4'd9; bus_if.rs_data = 32'h0000_3402; bus_if.imem_ready = 1'b0;
    tick();
    bus_if.br_type = 4'd0;
    tick();
    checks++;
    if (bus_if.pending !== 1'b1 || bus_if.pc !== 32'h3000) begin
      $display("FAIL jr_pend: got pc=%h pending=%b expected pc=%h pending=1",
               bus_if.pc, bus_if.pending, 32'h3000); errors++;
    end
    $display("jr pend: pc=%h pending=%b", bus_if.pc, bus_if.pending);
    bus_if.imem_ready = 1'b1;
    tick();
    checks++;
    if (bus_if.pc !== 32'h3402 || bus_if.pending !== 1'b0 || bus_if.misalign !== 1'b1) begin
      $display("FAIL jr_load: got pc=%h pending=%b misalign=%b expected pc=%h pending=0 misalign=1",
               bus_if.pc, bus_if.pending, bus_if.misalign, 32'h3402); errors++;
    end
    $display("jr load: pc=%h misalign=%b", bus_if.pc, bus_if.misalign);
    tick();
    checks++;
    if (bus_if.misalign !== 1'b0 || bus_if.pc !== 32'h3406) begin
      $display("FAIL jr_after: got pc=%h misalign=%b expected pc=%h misalign=0",
               bus_if.pc, bus_if.misalign, 32'h3406); errors++;
    end
  endtask

  task automatic test_jal_stall();
    do_reset();
    bus_if.br_type = 4'd8; bus_if.id_pc = 32'h0040_0010; bus_if.instr_index = 26'h0000100;
    bus_if.stall = 1'b1;
    #1;
    checks++;
    if (bus_if.link_addr !== 32'h0040_0018 || bus_if.redirect !== 1'b0) begin
      $display("FAIL jal_stall_comb: got link=%h redirect=%b expected link=%h redirect=0",
               bus_if.link_addr, bus_if.redirect, 32'h0040_0018); errors++;
    end
    tick();
    checks++;
    if (bus_if.pc !== 32'h3000) begin
      $display("FAIL jal_stall_pc: got %h expected %h", bus_if.pc, 32'h3000); errors++;
    end
    bus_if.stall = 1'b0;
    #1;
    checks++;
    if (bus_if.redirect !== 1'b1) begin
      $display("FAIL jal_redirect: got %b expected 1", bus_if.redirect); errors++;
    end
    tick();
    checks++;
    if (bus_if.pc !== 32'h0000_0400 || bus_if.misalign !== 1'b0) begin
      $display("FAIL jal_pc: got pc=%h misalign=%b expected pc=%h misalign=0",
               bus_if.pc, bus_if.misalign, 32'h0000_0400); errors++;
    end
    $display("jal: pc=%h link=%h", bus_if.pc, bus_if.link_addr);
  endtask

  task automatic test_reset_in_pend();
    do_reset();
    bus_if.br_type = 4'd1; bus_if.cmp_reg = 2'b00; bus_if.id_pc = 32'h3000;
    bus_if.imm16 = 16'h0040; bus_if.imem_ready = 1'b0;
    tick();
    checks++;
    if (bus_if.pending !== 1'b1) begin
      $display("FAIL pend_enter: got %b expected 1", bus_if.pending); errors++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus_if.pc !== 32'h3000 || bus_if.pending !== 1'b0) begin
      $display("FAIL pend_reset: got pc=%h pending=%b expected pc=%h pending=0",
               bus_if.pc, bus_if.pending, 32'h3000); errors++;
    end
    idle_inputs();
    tick();
    checks++;
    if (bus_if.pc !== 32'h3004) begin
      $display("FAIL pend_discard: got %h expected %h", bus_if.pc, 32'h3004); errors++;
    end
    $display("reset in pend: pc=%h", bus_if.pc);
  endtask

  task automatic test_random();
    int nerr_start;
    bit exp_red;
    nerr_start = errors;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset              = ($urandom_range(0, 49) == 0);
      bus_if.stall       = ($urandom_range(0, 4) == 0);
      bus_if.imem_ready  = ($urandom_range(0, 3) != 0);
      bus_if.br_type     = 4'($urandom_range(0, 15));
      bus_if.cmp_reg     = 2'($urandom_range(0, 3));
      bus_if.cmp_zero    = 2'($urandom_range(0, 3));
      bus_if.id_pc       = $urandom();
      bus_if.imm16       = 16'($urandom());
      bus_if.instr_index = 26'($urandom());
      bus_if.rs_data     = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      #1;
      exp_red = model_redirect();
      checks++;
      if (bus_if.redirect !== exp_red || bus_if.link_addr !== bus_if.id_pc + 32'd8) begin
        $display("FAIL rand_comb[%0d]: got redirect=%b link=%h expected redirect=%b link=%h",
                 i, bus_if.redirect, bus_if.link_addr, exp_red, bus_if.id_pc + 32'd8); errors++;
      end
      tick();
      checks++;
      if (bus_if.pc !== m_pc || bus_if.pending !== m_pend || bus_if.misalign !== m_mis) begin
        $display("FAIL rand_state[%0d]: got pc=%h pending=%b misalign=%b expected pc=%h pending=%b misalign=%b",
                 i, bus_if.pc, bus_if.pending, bus_if.misalign, m_pc, m_pend, m_mis); errors++;
      end
    end
    reset = 1'b0;
    $display("random: 400 cycles, %0d new errors", errors - nerr_start);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    m_pc = 32'h3000; m_pend = 1'b0; m_tgt = 32'd0; m_mis = 1'b0;
    test_reset();
    test_sequential();
    test_beq();
    test_bltz_bgez();
    test_jr_backpressure();
    test_jal_stall();
    test_reset_in_pend();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
